// File: rtl/aes_round_tail.sv
// AES round tail: ShiftRows -> MixColumns (bypassed on last round) -> AddRoundKey,
// registered behind a valid/ready handshake with a one-entry skid buffer.
module aes_round_tail (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] sub_data,
  input  logic [127:0] round_key,
  input  logic         in_last,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [127:0] out_data,
  output logic         out_last,
  output logic         out_valid,
  input  logic         out_ready
);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte k sits at bits [127-8k -: 8]; state s[r][c] is byte 4c+r.
  function automatic logic [127:0] round_fn(input logic [127:0] s,
                                            input logic [127:0] key,
                                            input logic         last);
    logic [7:0]   sb [16];
    logic [7:0]   tb [16];
    logic [7:0]   mb [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] res;
    for (int unsigned k = 0; k < 16; k++) sb[k] = s[127-8*k -: 8];
    for (int unsigned c = 0; c < 4; c++)
      for (int unsigned r = 0; r < 4; r++)
        tb[4*c+r] = sb[4*((c+r)%4)+r];
    for (int unsigned c = 0; c < 4; c++) begin
      a0 = tb[4*c];
      a1 = tb[4*c+1];
      a2 = tb[4*c+2];
      a3 = tb[4*c+3];
      if (last) begin
        mb[4*c]   = a0;
        mb[4*c+1] = a1;
        mb[4*c+2] = a2;
        mb[4*c+3] = a3;
      end else begin
        mb[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        mb[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        mb[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        mb[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
    end
    res = '0;
    for (int unsigned k = 0; k < 16; k++) res[127-8*k -: 8] = mb[k] ^ key[127-8*k -: 8];
    return res;
  endfunction

  logic [127:0] out_data_d, out_data_q;
  logic         out_last_d, out_last_q;
  logic         out_valid_d, out_valid_q;
  logic [127:0] skid_data_d, skid_data_q;
  logic         skid_last_d, skid_last_q;
  logic         skid_valid_d, skid_valid_q;
  logic [127:0] new_data;
  logic         accept, emit;

  assign in_ready  = ~skid_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_valid = out_valid_q;

  always_comb begin
    new_data     = round_fn(sub_data, round_key, in_last);
    accept       = in_valid & ~skid_valid_q;
    emit         = out_valid_q & out_ready;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    out_valid_d  = out_valid_q;
    skid_data_d  = skid_data_q;
    skid_last_d  = skid_last_q;
    skid_valid_d = skid_valid_q;
    if (emit) begin
      if (skid_valid_q) begin
        out_data_d   = skid_data_q;
        out_last_d   = skid_last_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_data_d = new_data;
        out_last_d = in_last;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (!out_valid_q) begin
        out_data_d  = new_data;
        out_last_d  = in_last;
        out_valid_d = 1'b1;
      end else begin
        skid_data_d  = new_data;
        skid_last_d  = in_last;
        skid_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      skid_data_q  <= '0;
      skid_last_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      out_valid_q  <= out_valid_d;
      skid_data_q  <= skid_data_d;
      skid_last_q  <= skid_last_d;
      skid_valid_q <= skid_valid_d;
    end
  end

endmodule

// File: tb/tb_aes_round_tail.sv
// Directed bench for aes_round_tail: vector table plus backpressure, throughput
// and mid-operation reset sequences.
module tb_aes_round_tail;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] sub_data;
  logic [127:0] round_key;
  logic         in_last;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] out_data;
  logic         out_last;
  logic         out_valid;
  logic         out_ready;

  aes_round_tail dut (
    .clk       (clk),
    .rst       (rst),
    .sub_data  (sub_data),
    .round_key (round_key),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] sub;
    logic [127:0] key;
    logic         last;
    logic [127:0] exp;
    logic         exp_last;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs [NV];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int idx, input logic v);
    sub_data  = vecs[idx].sub;
    round_key = vecs[idx].key;
    in_last   = vecs[idx].last;
    in_valid  = v;
  endtask

  initial begin
    vecs[0] = '{128'hd42711aee0bf98f1b8b45de51e415230, 128'ha0fafe1788542cb123a339392a6c7605, 1'b0,
                128'ha49c7ff2689f352b6b5bea43026a5049, 1'b0};
    vecs[1] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h0, 1'b1,
                128'h00050a0f04090e03080d02070c01060b, 1'b1};
    vecs[2] = '{128'hdb135345db135345db135345db135345, 128'h0, 1'b0,
                128'h8e4da1bc8e4da1bc8e4da1bc8e4da1bc, 1'b0};
    vecs[3] = '{128'hf20a225cf20a225cf20a225cf20a225c, 128'h0, 1'b0,
                128'h9fdc589d9fdc589d9fdc589d9fdc589d, 1'b0};
    vecs[4] = '{128'hd4d4d4d5d4d4d4d5d4d4d4d5d4d4d4d5, 128'h0, 1'b0,
                128'hd5d5d7d6d5d5d7d6d5d5d7d6d5d5d7d6, 1'b0};
    vecs[5] = '{128'hd42711aee0bf98f1b8b45de51e415230, 128'ha0fafe1788542cb123a339392a6c7605, 1'b1,
                128'h7445a32768e07e1f9be228c8344beee0, 1'b1};
    vecs[6] = '{128'h0, {128{1'b1}}, 1'b0, {128{1'b1}}, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    sub_data = '0; round_key = '0; in_last = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_out_valid", {127'b0, out_valid}, 128'd0);
    chk("rst_out_data", out_data, 128'd0);
    chk("rst_out_last", {127'b0, out_last}, 128'd0);
    chk("rst_in_ready", {127'b0, in_ready}, 128'd1);

    // Single blocks through an empty stage: one-cycle latency.
    out_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      drive(i, 1'b1);
      step();
      chk($sformatf("vec%0d_valid", i), {127'b0, out_valid}, 128'd1);
      chk($sformatf("vec%0d_data", i), out_data, vecs[i].exp);
      chk($sformatf("vec%0d_last", i), {127'b0, out_last}, {127'b0, vecs[i].exp_last});
      in_valid = 1'b0;
      step();
      chk($sformatf("vec%0d_drain", i), {127'b0, out_valid}, 128'd0);
    end

    // Backpressure: A to main, B to skid, C held upstream.
    out_ready = 1'b0;
    drive(0, 1'b1); step();
    chk("bp_a_main", out_data, vecs[0].exp);
    chk("bp_a_ready", {127'b0, in_ready}, 128'd1);
    drive(1, 1'b1); step();
    chk("bp_b_ready", {127'b0, in_ready}, 128'd0);
    chk("bp_b_stable", out_data, vecs[0].exp);
    drive(2, 1'b1); step();
    chk("bp_c_ready", {127'b0, in_ready}, 128'd0);
    chk("bp_c_stable", out_data, vecs[0].exp);
    chk("bp_c_last", {127'b0, out_last}, 128'd0);
    step();
    chk("bp_hold_stable", out_data, vecs[0].exp);
    out_ready = 1'b1;
    step();
    chk("bp_out_b", out_data, vecs[1].exp);
    chk("bp_out_b_last", {127'b0, out_last}, 128'd1);
    chk("bp_ready_back", {127'b0, in_ready}, 128'd1);
    step();
    in_valid = 1'b0;
    chk("bp_out_c", out_data, vecs[2].exp);
    chk("bp_out_c_valid", {127'b0, out_valid}, 128'd1);
    step();
    chk("bp_empty", {127'b0, out_valid}, 128'd0);

    // Full throughput: one result per cycle, skid never used.
    for (int i = 0; i < 16; i++) begin
      drive(i % NV, 1'b1);
      step();
      chk($sformatf("tp%0d_ready", i), {127'b0, in_ready}, 128'd1);
      chk($sformatf("tp%0d_valid", i), {127'b0, out_valid}, 128'd1);
      chk($sformatf("tp%0d_data", i), out_data, vecs[i % NV].exp);
    end
    in_valid = 1'b0;
    step();
    chk("tp_drain", {127'b0, out_valid}, 128'd0);

    // Reset with main and skid both full; the reset-cycle transfer is ignored.
    out_ready = 1'b0;
    drive(0, 1'b1); step();
    drive(1, 1'b1); step();
    chk("mr_full", {127'b0, in_ready}, 128'd0);
    rst = 1'b1; out_ready = 1'b1; drive(2, 1'b1);
    step();
    rst = 1'b0; in_valid = 1'b0;
    chk("mr_out_valid", {127'b0, out_valid}, 128'd0);
    chk("mr_out_data", out_data, 128'd0);
    chk("mr_out_last", {127'b0, out_last}, 128'd0);
    chk("mr_in_ready", {127'b0, in_ready}, 128'd1);
    step();
    chk("mr_still_empty", {127'b0, out_valid}, 128'd0);
    drive(3, 1'b1); step();
    in_valid = 1'b0;
    chk("mr_new_valid", {127'b0, out_valid}, 128'd1);
    chk("mr_new_data", out_data, vecs[3].exp);
    step();
    chk("mr_no_stale", {127'b0, out_valid}, 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
